led_bar_decoder: RTL

//  Reader side of the 8-LED countdown bar: samples the driven LED bus, strips the 3 Hz blink,

---
 rtl/led_bar_pkg.sv | 17 +
 rtl/led_bar_decoder_thermo_check.sv | 24 ++
 rtl/led_bar_decoder.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/led_bar_pkg.sv
// Shared types and sizing helpers for the LED countdown bar reader.
package led_bar_pkg;

   localparam int LED_W_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_COUNTING = 2'd1,
      ST_FULL     = 2'd2
   } led_state_e;

   // Bits needed to hold a level in 0..w inclusive.
   function automatic int lvl_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/led_bar_decoder_thermo_check.sv
// Combinational popcount and LSB-justified thermometer check.
module thermo_check #(
   parameter int W  = 8,
   parameter int CW = $clog2(W + 1)
) (
   input  logic [W-1:0]  data,
   output logic [CW-1:0] count,
   output logic          valid
);

   logic [W-1:0] data_plus1;

   always_comb begin
      count = '0;
      for (int i = 0; i < W; i++) begin
         count = count + CW'(data[i]);
      end
   end

   // A thermometer (or zero) has no set bit above the first carry position.
   assign data_plus1 = data + W'(1);
   assign valid      = ((data & data_plus1) == '0);

endmodule

// File: rtl/led_bar_decoder.sv
// Reads the LED bar bus, removes blinking and recovers the countdown stage.
module led_bar_decoder
   import led_bar_pkg::*;
#(
   parameter  int LED_W      = LED_W_DEF,
   parameter  int HOLD_TICKS = 40,
   parameter  int ERR_TICKS  = 2,
   localparam int LVL_W      = lvl_width(LED_W)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic [LED_W-1:0] led_in,
   output logic [LVL_W-1:0] level,
   output logic [1:0]       state,
   output logic             blinking,
   output logic             stage_pulse,
   output logic             boom,
   output logic             pattern_err
);

   localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
   localparam int ERR_W  = $clog2(ERR_TICKS + 1);

   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_TICKS);
   localparam logic [ERR_W-1:0]  ERR_MAX  = ERR_W'(ERR_TICKS);
   localparam logic [LVL_W-1:0]  LVL_FULL = LVL_W'(LED_W);

   logic [LED_W-1:0]  sync1_q, sync2_q;
   logic [LVL_W-1:0]  level_q, level_d;
   led_state_e        state_q, state_d;
   logic              blinking_q, blinking_d;
   logic              stage_pulse_q, stage_pulse_d;
   logic              boom_q, boom_d;
   logic              pattern_err_q, pattern_err_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [HOLD_W-1:0] steady_cnt_q, steady_cnt_d;
   logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;

   logic [LVL_W-1:0]  lit_cnt;
   logic              lit_valid;

   thermo_check #(
      .W  (LED_W),
      .CW (LVL_W)
   ) u_thermo_check (
      .data  (sync2_q),
      .count (lit_cnt),
      .valid (lit_valid)
   );

   always_comb begin
      level_d       = level_q;
      state_d       = state_q;
      blinking_d    = blinking_q;
      stage_pulse_d = 1'b0;
      boom_d        = 1'b0;
      pattern_err_d = pattern_err_q;
      hold_cnt_d    = hold_cnt_q;
      steady_cnt_d  = steady_cnt_q;
      err_cnt_d     = err_cnt_q;

      if (tick) begin
         if (!lit_valid) begin
            if (err_cnt_q != ERR_MAX) begin
               err_cnt_d = err_cnt_q + ERR_W'(1);
            end
            if (err_cnt_d == ERR_MAX) begin
               pattern_err_d = 1'b1;
            end
         end else if (lit_cnt == '0) begin
            // Dark tick: either a blink off-phase or the bar being cleared.
            err_cnt_d    = '0;
            steady_cnt_d = '0;
            if (hold_cnt_q != HOLD_MAX) begin
               hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
            if (hold_cnt_d == HOLD_MAX) begin
               level_d    = '0;
               state_d    = ST_IDLE;
               blinking_d = 1'b0;
            end
         end else begin
            err_cnt_d  = '0;
            hold_cnt_d = '0;
            if (hold_cnt_q != '0 && hold_cnt_q != HOLD_MAX) begin
               blinking_d = 1'b1;
            end
            if (steady_cnt_q != HOLD_MAX) begin
               steady_cnt_d = steady_cnt_q + HOLD_W'(1);
            end
            if (blinking_q && steady_cnt_d == HOLD_MAX) begin
               blinking_d = 1'b0;
            end
            if (lit_cnt > level_q) begin
               level_d       = lit_cnt;
               stage_pulse_d = 1'b1;
            end else if (lit_cnt < level_q) begin
               level_d = lit_cnt;
            end
            if (lit_cnt == LVL_FULL) begin
               state_d = ST_FULL;
               boom_d  = (state_q != ST_FULL);
            end else begin
               state_d = ST_COUNTING;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q       <= '0;
         sync2_q       <= '0;
         level_q       <= '0;
         state_q       <= ST_IDLE;
         blinking_q    <= 1'b0;
         stage_pulse_q <= 1'b0;
         boom_q        <= 1'b0;
         pattern_err_q <= 1'b0;
         hold_cnt_q    <= '0;
         steady_cnt_q  <= '0;
         err_cnt_q     <= '0;
      end else begin
         sync1_q       <= led_in;
         sync2_q       <= sync1_q;
         level_q       <= level_d;
         state_q       <= state_d;
         blinking_q    <= blinking_d;
         stage_pulse_q <= stage_pulse_d;
         boom_q        <= boom_d;
         pattern_err_q <= pattern_err_d;
         hold_cnt_q    <= hold_cnt_d;
         steady_cnt_q  <= steady_cnt_d;
         err_cnt_q     <= err_cnt_d;
      end
   end

   assign level       = level_q;
   assign state       = state_q;
   assign blinking    = blinking_q;
   assign stage_pulse = stage_pulse_q;
   assign boom        = boom_q;
   assign pattern_err = pattern_err_q;

endmodule
